// File: rtl/sprite_pkg.sv
// sprite_pkg: element codes, sprite sizes, size lookup and FSM state encoding for sprite_locator
package sprite_pkg;
  localparam int EL_SPRITE1 = 1;
  localparam int EL_SPRITE2 = 2;
  localparam int EL_SPRITE3 = 3;
  localparam int EL_BACKGROUND = 4;
  localparam int EL_SPRITE5 = 5;
  localparam int SIZE_SPRITE1 = 25;
  localparam int SIZE_SPRITE2 = 16;
  localparam int SIZE_SPRITE3 = 20;
  localparam int SIZE_BACKGROUND = 100;
  localparam int SIZE_SPRITE5 = 25;
  localparam int MAX_SPRITE_DIM = 32;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  function automatic logic [6:0] size_of(input logic [31:0] el);
    return el == EL_SPRITE1 ? 7'(SIZE_SPRITE1) :
           el == EL_SPRITE2 ? 7'(SIZE_SPRITE2) :
           el == EL_SPRITE3 ? 7'(SIZE_SPRITE3) :
           el == EL_BACKGROUND ? 7'(SIZE_BACKGROUND) :
           el == EL_SPRITE5 ? 7'(SIZE_SPRITE5) : 7'd0;
  endfunction
endpackage

// File: rtl/sprite_slot_table.sv
// sprite_slot_table: sprite register file with validated write port, wr_err pulse and one combinational read port
module sprite_slot_table
  import sprite_pkg::*;
#(
  parameter int SLOTS = 8,
  parameter int ELEMENTS = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(SLOTS)-1:0] wr_slot,
  input  logic                     wr_active,
  input  logic [9:0]               wr_x,
  input  logic [9:0]               wr_y,
  input  logic [ELEMENTS-1:0]      wr_element,
  output logic                     wr_err,
  input  logic [$clog2(SLOTS)-1:0] rd_slot,
  output logic                     rd_active,
  output logic [9:0]               rd_x,
  output logic [9:0]               rd_y,
  output logic [ELEMENTS-1:0]      rd_element
);
  logic                active_q [SLOTS];
  logic [9:0]          x_q [SLOTS];
  logic [9:0]          y_q [SLOTS];
  logic [ELEMENTS-1:0] el_q [SLOTS];
  logic [6:0]          wr_size;
  logic                wr_ok;
  assign wr_size = size_of(32'(wr_element));
  assign wr_ok = !wr_active || (wr_size != 7'd0 && wr_size <= 7'(MAX_SPRITE_DIM));
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < SLOTS; i++) active_q[i] <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_err <= wr_en && !wr_ok;
      if (wr_en && wr_ok) begin
        active_q[wr_slot] <= wr_active;
        x_q[wr_slot] <= wr_x;
        y_q[wr_slot] <= wr_y;
        el_q[wr_slot] <= wr_element;
      end
    end
  end
  assign rd_active = active_q[rd_slot];
  assign rd_x = x_q[rd_slot];
  assign rd_y = y_q[rd_slot];
  assign rd_element = el_q[rd_slot];
endmodule

// File: rtl/sprite_locator.sv
// sprite_locator: scans the sprite table one slot per cycle and issues a sprite memory read for the first covering sprite
module sprite_locator
  import sprite_pkg::*;
#(
  parameter int SLOTS = 8,
  parameter int ELEMENTS = 5,
  parameter int ADDR_W = 10
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [$clog2(SLOTS)-1:0] wr_slot,
  input  logic                     wr_active,
  input  logic [9:0]               wr_x,
  input  logic [9:0]               wr_y,
  input  logic [ELEMENTS-1:0]      wr_element,
  output logic                     wr_err,
  input  logic                     pix_valid,
  input  logic [9:0]               pix_x,
  input  logic [9:0]               pix_y,
  output logic                     pix_ready,
  output logic                     read_enable,
  output logic [ADDR_W-1:0]        address_sprite,
  output logic [ELEMENTS-1:0]      element,
  output logic                     result_valid,
  output logic                     hit,
  output logic [$clog2(SLOTS)-1:0] hit_slot
);
  localparam int SW = $clog2(SLOTS);
  state_t              state;
  logic [SW-1:0]       cnt;
  logic [9:0]          px;
  logic [9:0]          py;
  logic                t_active;
  logic [9:0]          t_x;
  logic [9:0]          t_y;
  logic [ELEMENTS-1:0] t_el;
  logic [6:0]          s;
  logic [10:0]         x_end;
  logic [10:0]         y_end;
  logic                match;
  logic [4:0]          dx;
  logic [4:0]          dy;
  logic [11:0]         prod;
  sprite_slot_table #(.SLOTS(SLOTS), .ELEMENTS(ELEMENTS)) u_table (
    .clk(clk),
    .reset(reset),
    .wr_en(wr_en),
    .wr_slot(wr_slot),
    .wr_active(wr_active),
    .wr_x(wr_x),
    .wr_y(wr_y),
    .wr_element(wr_element),
    .wr_err(wr_err),
    .rd_slot(cnt),
    .rd_active(t_active),
    .rd_x(t_x),
    .rd_y(t_y),
    .rd_element(t_el)
  );
  always_comb begin
    s = size_of(32'(t_el));
    x_end = {1'b0, t_x} + {4'd0, s};
    y_end = {1'b0, t_y} + {4'd0, s};
    match = t_active && px >= t_x && {1'b0, px} < x_end && py >= t_y && {1'b0, py} < y_end;
    dx = 5'(px - t_x);
    dy = 5'(py - t_y);
    prod = {7'd0, dy} * {5'd0, s};
  end
  assign pix_ready = state == IDLE && !reset;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      px <= '0;
      py <= '0;
      read_enable <= 1'b0;
      address_sprite <= '0;
      element <= '0;
      result_valid <= 1'b0;
      hit <= 1'b0;
      hit_slot <= '0;
    end else begin
      read_enable <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: if (pix_valid) begin
          px <= pix_x;
          py <= pix_y;
          cnt <= '0;
          state <= SCAN;
        end
        SCAN: if (match) begin
          state <= DONE;
          hit <= 1'b1;
          hit_slot <= cnt;
          address_sprite <= ADDR_W'(prod + {7'd0, dx});
          element <= t_el;
          result_valid <= 1'b1;
          read_enable <= 1'b1;
        end else if (cnt == SW'(SLOTS - 1)) begin
          state <= DONE;
          hit <= 1'b0;
          result_valid <= 1'b1;
        end else begin
          cnt <= cnt + SW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/sprite_locator.md
# sprite_locator

Pixel-to-sprite resolver that sits directly upstream of `memorySprites`. It holds a small table of placed sprites, each with an on-screen position and an element code. For each requested screen pixel it finds the highest-priority sprite covering that pixel and computes the sprite-local memory address. It then issues a one-cycle read request (`read_enable`, `address_sprite`, `element`) to the sprite memory.

## Interface

Parameters:
- `SLOTS`, default 8: number of sprite table entries. Must be a power of two, 2–16.
- `ELEMENTS`, default 5: width of the element code, matching the sprite memory's `element` port.
- `ADDR_W`, default 10: sprite address width. Sprites may be at most 32x32.

Ports (clock and reset first):
- `clk`, in, 1: single clock. Reset is synchronous and active-high.
- `reset`, in, 1: synchronous, active-high.
- `wr_en`, in, 1: write one table slot.
- `wr_slot`, in, $clog2(SLOTS): slot index.
- `wr_active`, in, 1: slot enable.
- `wr_x`, in, 10: sprite top-left x.
- `wr_y`, in, 10: sprite top-left y.
- `wr_element`, in, ELEMENTS: element code, 1..5.
- `wr_err`, out, 1: one-cycle pulse when a write is rejected.
- `pix_valid`, in, 1: pixel lookup request.
- `pix_x`, in, 10: pixel x.
- `pix_y`, in, 10: pixel y.
- `pix_ready`, out, 1: high only in IDLE.
- `read_enable`, out, 1: one-cycle read strobe to sprite memory.
- `address_sprite`, out, ADDR_W: sprite-local address.
- `element`, out, ELEMENTS: element code of the hit sprite.
- `result_valid`, out, 1: one-cycle completion pulse.
- `hit`, out, 1: a sprite covered the pixel. Valid with `result_valid`.
- `hit_slot`, out, $clog2(SLOTS): winning slot. Valid with `result_valid`.

## Operation

- **Table contents.** Each slot holds `{active, x, y, element}`.
- **Write validity.** A write is accepted if `wr_element` is in 1..5 and the element's size is ≤ 32.
  - Otherwise the write is ignored and `wr_err` pulses on the next cycle.
  - Element 4 (background, size 100) is therefore always rejected.
  - Writes with `wr_active=0` are never rejected.
- **Write timing.** Writes are accepted in every FSM state and update the table at the clock edge. A slot compared in cycle c sees all writes from edges before c.
- **FSM states:** IDLE, SCAN, DONE.
  - IDLE: when `pix_valid && pix_ready`, latch `pix_x`/`pix_y`, set slot counter to 0, go to SCAN.
  - SCAN: compare one slot per cycle, in ascending slot order.
    - On the first hit, register the address, element and slot, and go to DONE with hit=1.
    - If the last slot misses, go to DONE with hit=0.
  - DONE: pulse `result_valid` for one cycle.
    - If hit=1, `read_enable` pulses in the same cycle.
    - Go to IDLE.
- **Priority.** The lowest slot index wins.
- **Hit test**, with `S = size(element)` and 11-bit unsigned sums so that x/y near 1023 cannot wrap:
  - `active`
  - `px ≥ x` and `px < x + S`
  - `py ≥ y` and `py < y + S`
- **Address.** `(py − y) * S + (px − x)`. Maximum value is 1023, so there is no truncation at `ADDR_W=10`.
- **Output holding.** `address_sprite` and `element` hold their last hit values between reads. `read_enable` is the only strobe.

## Timing

- **Accept.** A request is accepted in cycle 0. Slot k is compared in cycle k+1.
- **Latency.**
  - Hit at slot k: `result_valid` and `read_enable` are high in cycle k+2.
  - Miss: `result_valid` is high in cycle SLOTS+1, with `read_enable` low.
- **Throughput.** `pix_ready` returns high in the cycle after DONE. Minimum spacing between requests is 3 cycles (hit at slot 0).
- **Reset.** Reset has priority over every event, including a simultaneous `wr_en`. It clears all slots to `active=0` and sets the state to IDLE. All outputs go to 0: `read_enable`, `address_sprite`, `element`, `result_valid`, `hit`, `hit_slot`, `wr_err`.
  - `pix_ready` is 0 while `reset` is high and 1 in the first cycle after.
- **Reset mid-scan.** The in-flight pixel is dropped. No `read_enable` or `result_valid` is issued for it.
- **Ignored requests.** `pix_valid` while `pix_ready=0` is ignored and not queued.

## Structure

- Package `sprite_pkg` contains:
  - Element code constants 1..5.
  - Element size constants: 25, 16, 20, 100, 25.
  - `MAX_SPRITE_DIM = 32`.
  - A `size_of(element)` function that returns 0 for invalid codes.
  - FSM state encoding.
- Sub-module `sprite_slot_table`: the register file with the write port, validity check, `wr_err` generation and one combinational read port indexed by the slot counter.
- The top level contains the FSM, the hit compare and the address multiply-add. The multiply is 5x5 bits and needs no pipelining.

## Test plan

- **Reset.** Hold reset 2 cycles with stray `pix_valid` and `wr_en` high.
  - Every output is 0 during reset.
  - `pix_ready=1` in the first cycle after.
  - A following lookup at (0,0) gives hit=0 after SLOTS+1 cycles.
- **Single hit.** Slot 3 = {1, 100, 50, el 1}; lookup (112, 60).
  - `read_enable` and `result_valid` in cycle 5.
  - element=1, `address_sprite`=10*25+12=262, `hit_slot`=3.
- **Edges and priority.** Slot 0 = {1, 10, 10, el 2}, slot 1 = {1, 10, 10, el 1}.
  - (25,25): hit, slot 0, address 255.
  - (26,10): slot 1, address 16.
  - (35,10): miss.
- **Wrap-free bounds.** Slot 2 = {1, 1020, 1020, el 3}; lookup (1023, 1023).
  - hit, address 3*20+3=63.
  - Lookup (5, 5) misses; no false hit from 11-bit sums.
- **Rejected writes.** Write el 4 to slot 0: `wr_err` pulses, the slot is unchanged. Same for el 0 and el 6.
  - A write with `wr_active=0` and el 7 raises no `wr_err`.
- **Write during scan, then reset mid-scan.** Write slot 5 while the scan is at slot 2; the new value is used when slot 5 is compared. Then assert reset during SCAN.
  - No `read_enable` or `result_valid` for the dropped pixel.
  - All slots are inactive afterward.
